johnson_decode_checker: RTL and testbench
=========================================

// Module: johnson_decode_checker
// PURPOSE
//   Receive-side companion to johnson_counter: samples an N-bit Johnson-coded bus, decodes it to a
//   binary phase index 0..2N-1, flags illegal codes and out-of-sequence steps, and tracks lock.
//   Sits downstream of any johnson_counter instance, for phase decode and run-time integrity checks.
// PARAMETERS
//   N          4   width of Johnson bus; 2N legal codes; N>=2
//   LOCK_CNT   3   consecutive good steps needed to declare lock; 1..15
//   ALLOW_HOLD 0   1: a repeated code (same index) is a legal step; 0: counts as sequence error
//   ECW        8   width of saturating error counter
// PORTS
//   clk        in   1          rising-edge clock
//   reset      in   1          synchronous, active-high reset
//   q_in       in   N          Johnson-coded bus under test
//   sample_en  in   1          1 = evaluate q_in this cycle; 0 = hold all state and outputs
//   clr_err    in   1          synchronous clear of err_count and sticky alarm
//   idx        out  IW         decoded index, IW=$clog2(2N); valid when idx_valid=1
//   idx_valid  out  1          last sample was a legal code
//   illegal    out  1          1-cycle pulse: last sample not a legal Johnson code
//   seq_err    out  1          1-cycle pulse: legal code but not prev+1 (mod 2N)
//   wrap       out  1          1-cycle pulse: legal step from idx 2N-1 to idx 0
//   locked     out  1          state==LOCKED
//   alarm      out  1          sticky: any error seen while LOCKED
//   err_count  out  ECW        saturating count of illegal+seq_err events
// BEHAVIOUR
//   - Code convention (matches johnson_counter): step k -> next = {q[N-2:0], ~q[N-1]} from 0..0.
//     N=4 sequence idx0..7: 0000,0001,0011,0111,1111,1110,1100,1000.
//   - Decode: p=popcount(q_in); idx = q_in[N-1] ? 2N-p : p. Legal iff encode(idx)==q_in.
//   - All outputs registered; 1-cycle latency from sampled q_in. Pulses high exactly one cycle.
//   - Reset: idx=0, idx_valid=0, illegal=seq_err=wrap=0, locked=0, alarm=0, err_count=0,
//     state=ACQUIRE, good_cnt=0, prev_valid=0. Reset mid-run discards history completely.
//   - sample_en=0: registers hold, pulses deassert next cycle, counters unchanged.
//   - Step classification (sample_en=1, prev_valid=1, code legal):
//     GOOD if idx==prev+1 mod 2N; HOLD if idx==prev; else SEQ. HOLD->GOOD-neutral if ALLOW_HOLD,
//     (good_cnt unchanged), else treated as SEQ. First legal sample after reset/illegal: NEUTRAL.
//   - FSM: ACQUIRE: GOOD -> good_cnt++; good_cnt reaching LOCK_CNT -> LOCKED. SEQ/illegal ->
//     good_cnt=0, stay. LOCKED: GOOD/HOLD stay; SEQ/illegal -> set alarm, -> ACQUIRE, good_cnt=0.
//   - Illegal code: illegal=1, idx_valid=0, idx holds last value, prev_valid=0.
//   - err_count += 1 on illegal or seq_err, saturates at 2^ECW-1. clr_err same cycle as an error:
//     clear wins, error not counted; alarm cleared. reset overrides clr_err.
//   - wrap asserts only on a GOOD step 2N-1 -> 0; counter reset to 0000 from other idx is SEQ.
// STRUCTURE
//   - Package johnson_pkg: function jc_encode(idx) and jc_decode(q) -> {legal, idx}; FSM enum
//     {ACQUIRE, LOCKED}; IW localparam helper. Shared with johnson_counter bench checker.
//   - One sub-module: johnson_decode (combinational decode + legality, per package functions);
//     top holds prev_idx, good_cnt, FSM, pulse regs, err_count.
// TESTING  (N=4, LOCK_CNT=3, ALLOW_HOLD=0, ECW=8)
//   1. Drive johnson_counter, reset 1 cycle -> after 4 samples (0000 neutral + 3 GOOD) locked=1;
//      idx tracks 0..7, wrap pulses once per 8 cycles, err_count=0.
//   2. Force q_in=0101 while locked -> illegal=1 one cycle, idx_valid=0, locked=0, alarm=1,
//      err_count=1; relock 4 samples later.
//   3. Skip step 0011->1111 while locked -> seq_err=1, idx=4, err_count+1, locked=0, alarm=1.
//   4. Counter reset to 0000 from idx 5 mid-run -> seq_err=1, no wrap; clr_err -> err_count=0,
//      alarm=0; relock after 3 further GOOD steps.
//   5. sample_en low 5 cycles with q_in changing -> all outputs frozen; ALLOW_HOLD=1 repeat code
//      -> no seq_err, locked stays 1.
//   6. 300 forced illegal samples -> err_count saturates 255; reset mid-run -> all outputs 0 next cycle.

Source files
------------

// File: rtl/johnson_pkg.sv
// Shared Johnson-code helpers: encode/decode functions, checker FSM states and index-width helper.
package johnson_pkg;

  localparam int JC_MAXN = 32;

  typedef enum logic {
    ACQUIRE = 1'b0,
    LOCKED  = 1'b1
  } jc_state_t;

  typedef struct packed {
    logic        legal;
    logic [31:0] idx;
  } jc_dec_t;

  function automatic int jc_iw(input int n);
    return $clog2(2 * n);
  endfunction

  // Index k <= n has k low ones; k > n has ones from bit k-n up to bit n-1.
  function automatic logic [JC_MAXN-1:0] jc_encode(input int idx, input int n);
    logic [JC_MAXN-1:0] code;
    code = {JC_MAXN{1'b0}};
    for (int i = 0; i < JC_MAXN; i++) begin
      if (i >= n) begin
        code[i] = 1'b0;
      end else if (idx <= n) begin
        code[i] = (i < idx);
      end else begin
        code[i] = (i >= idx - n);
      end
    end
    return code;
  endfunction

  function automatic jc_dec_t jc_decode(input logic [JC_MAXN-1:0] q, input int n);
    jc_dec_t r;
    int      p;
    p = 0;
    for (int i = 0; i < JC_MAXN; i++) begin
      if (q[i]) begin
        p = p + 1;
      end else begin
        p = p + 0;
      end
    end
    r.idx   = q[n-1] ? 32'(2 * n - p) : 32'(p);
    r.legal = (jc_encode(int'(r.idx), n) == q);
    return r;
  endfunction

endpackage

// File: rtl/johnson_decode.sv
// Combinational Johnson-code decode: phase index plus legality of the presented code.
module johnson_decode
  import johnson_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = 3
) (
  input  logic [N-1:0]  q,
  output logic          legal,
  output logic [IW-1:0] idx
);

  logic [JC_MAXN-1:0] q_ext_s;
  jc_dec_t            dec_s;
  logic               unused_idx_s;

  // Zero-extend into the package's fixed-width helpers.
  always_comb begin
    q_ext_s        = {JC_MAXN{1'b0}};
    q_ext_s[N-1:0] = q;
    dec_s          = jc_decode(q_ext_s, N);
  end

  assign legal        = dec_s.legal;
  assign idx          = dec_s.idx[IW-1:0];
  assign unused_idx_s = ^dec_s.idx;

endmodule

// File: rtl/johnson_decode_checker.sv
// Receive-side Johnson bus checker: registered phase decode, step classification,
// lock tracking, sticky alarm and saturating error counter.
module johnson_decode_checker
  import johnson_pkg::*;
#(
  parameter int N          = 4,
  parameter int LOCK_CNT   = 3,
  parameter int ALLOW_HOLD = 0,
  parameter int ECW        = 8,
  localparam int IW        = jc_iw(N)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [N-1:0]   q_in,
  input  logic           sample_en,
  input  logic           clr_err,
  output logic [IW-1:0]  idx,
  output logic           idx_valid,
  output logic           illegal,
  output logic           seq_err,
  output logic           wrap,
  output logic           locked,
  output logic           alarm,
  output logic [ECW-1:0] err_count
);

  localparam logic [IW-1:0] LAST_IDX = IW'(2 * N - 1);

  logic            dec_legal_s;
  logic [IW-1:0]   dec_idx_s;
  logic [IW-1:0]   succ_s;
  logic            step_good_s, step_hold_s, good_evt_s, fault_s;
  jc_state_t       state_r, state_s;
  logic [3:0]      good_cnt_r, good_cnt_s;
  logic            prev_valid_r, prev_valid_s;
  logic [IW-1:0]   idx_s;
  logic            idx_valid_s, illegal_s, seq_err_s, wrap_s, alarm_s;
  logic [ECW-1:0]  err_count_s;

  johnson_decode #(.N(N), .IW(IW)) u_decode (
    .q     (q_in),
    .legal (dec_legal_s),
    .idx   (dec_idx_s)
  );

  // idx register doubles as the previous legal index.
  assign succ_s      = (idx == LAST_IDX) ? {IW{1'b0}} : idx + IW'(1'b1);
  assign step_good_s = (dec_idx_s == succ_s);
  assign step_hold_s = (dec_idx_s == idx);
  assign locked      = (state_r == LOCKED);

  // Classify the sample, then advance FSM, alarm and error counter.
  always_comb begin
    state_s      = state_r;
    good_cnt_s   = good_cnt_r;
    prev_valid_s = prev_valid_r;
    idx_s        = idx;
    idx_valid_s  = idx_valid;
    illegal_s    = 1'b0;
    seq_err_s    = 1'b0;
    wrap_s       = 1'b0;
    alarm_s      = alarm;
    err_count_s  = err_count;
    fault_s      = 1'b0;
    good_evt_s   = 1'b0;
    if (sample_en) begin
      if (dec_legal_s) begin
        idx_s        = dec_idx_s;
        idx_valid_s  = 1'b1;
        prev_valid_s = 1'b1;
        if (!prev_valid_r) begin
          good_evt_s = 1'b0;
        end else if (step_good_s) begin
          good_evt_s = 1'b1;
          wrap_s     = (idx == LAST_IDX);
        end else if (step_hold_s && (ALLOW_HOLD != 32'sd0)) begin
          good_evt_s = 1'b0;
        end else begin
          seq_err_s = 1'b1;
          fault_s   = 1'b1;
        end
      end else begin
        illegal_s    = 1'b1;
        idx_valid_s  = 1'b0;
        prev_valid_s = 1'b0;
        fault_s      = 1'b1;
      end
    end else begin
      fault_s = 1'b0;
    end
    case (state_r)
      ACQUIRE: begin
        if (fault_s) begin
          good_cnt_s = 4'd0;
        end else if (good_evt_s) begin
          if ((good_cnt_r + 4'd1) >= 4'(LOCK_CNT)) begin
            state_s    = LOCKED;
            good_cnt_s = 4'd0;
          end else begin
            good_cnt_s = good_cnt_r + 4'd1;
          end
        end else begin
          good_cnt_s = good_cnt_r;
        end
      end
      LOCKED: begin
        if (fault_s) begin
          alarm_s    = 1'b1;
          state_s    = ACQUIRE;
          good_cnt_s = 4'd0;
        end else begin
          state_s = LOCKED;
        end
      end
      default: begin
        state_s    = ACQUIRE;
        good_cnt_s = 4'd0;
      end
    endcase
    if (clr_err) begin
      err_count_s = {ECW{1'b0}};
      alarm_s     = 1'b0;
    end else if (fault_s && (err_count != {ECW{1'b1}})) begin
      err_count_s = err_count + ECW'(1'b1);
    end else begin
      err_count_s = err_count;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= ACQUIRE;
      good_cnt_r   <= 4'd0;
      prev_valid_r <= 1'b0;
      idx          <= {IW{1'b0}};
      idx_valid    <= 1'b0;
      illegal      <= 1'b0;
      seq_err      <= 1'b0;
      wrap         <= 1'b0;
      alarm        <= 1'b0;
      err_count    <= {ECW{1'b0}};
    end else begin
      state_r      <= state_s;
      good_cnt_r   <= good_cnt_s;
      prev_valid_r <= prev_valid_s;
      idx          <= idx_s;
      idx_valid    <= idx_valid_s;
      illegal      <= illegal_s;
      seq_err      <= seq_err_s;
      wrap         <= wrap_s;
      alarm        <= alarm_s;
      err_count    <= err_count_s;
    end
  end

endmodule

// File: tb/tb_johnson_decode_checker.sv
// Randomized self-checking bench: two checkers (hold illegal / hold allowed) against a
// table-lookup behavioural model, plus directed scenarios with literal expectations.
module tb_johnson_decode_checker;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] q_in = 4'b0000;
  logic       sample_en = 1'b0;
  logic       clr_err = 1'b0;

  logic [2:0] idx0, idx1;
  logic       iv0, iv1, il0, il1, se0, se1, wr0, wr1, lk0, lk1, al0, al1;
  logic [7:0] ec0, ec1;

  int total = 0;
  int bad   = 0;
  int cnt   = 0;
  bit chk_on = 1'b0;

  logic [3:0] codes [8] = '{4'b0000, 4'b0001, 4'b0011, 4'b0111,
                            4'b1111, 4'b1110, 4'b1100, 4'b1000};

  typedef struct packed {
    int idx; int good; int err;
    bit pv; bit locked; bit alarm; bit idx_valid; bit illegal; bit seq_err; bit wrap;
  } mst_t;

  mst_t m0, m1;

  johnson_decode_checker #(.N(4), .LOCK_CNT(3), .ALLOW_HOLD(0), .ECW(8)) dut0 (
    .clk(clk), .reset(reset), .q_in(q_in), .sample_en(sample_en), .clr_err(clr_err),
    .idx(idx0), .idx_valid(iv0), .illegal(il0), .seq_err(se0), .wrap(wr0),
    .locked(lk0), .alarm(al0), .err_count(ec0));

  johnson_decode_checker #(.N(4), .LOCK_CNT(3), .ALLOW_HOLD(1), .ECW(8)) dut1 (
    .clk(clk), .reset(reset), .q_in(q_in), .sample_en(sample_en), .clr_err(clr_err),
    .idx(idx1), .idx_valid(iv1), .illegal(il1), .seq_err(se1), .wrap(wr1),
    .locked(lk1), .alarm(al1), .err_count(ec1));

  always #5 clk = ~clk;

  // Reference behaviour: look the code up in the legal table, then apply the step rules.
  function automatic mst_t mstep(mst_t s, bit rst, bit en, bit clr, logic [3:0] q, bit allow);
    mst_t n;
    int   k;
    bit   err;
    n = s;
    err = 1'b0;
    if (rst) begin
      n = '0;
      return n;
    end
    n.illegal = 1'b0; n.seq_err = 1'b0; n.wrap = 1'b0;
    if (en) begin
      k = -1;
      for (int i = 0; i < 8; i++) if (codes[i] == q) k = i;
      if (k < 0) begin
        n.illegal = 1'b1; n.idx_valid = 1'b0; n.pv = 1'b0; n.good = 0; err = 1'b1;
        if (s.locked) begin n.alarm = 1'b1; n.locked = 1'b0; end
      end else begin
        n.idx = k; n.idx_valid = 1'b1; n.pv = 1'b1;
        if (s.pv) begin
          if (k == (s.idx + 1) % 8) begin
            if (s.idx == 7) n.wrap = 1'b1;
            if (!s.locked) begin
              n.good = s.good + 1;
              if (n.good >= 3) begin n.locked = 1'b1; n.good = 0; end
            end
          end else if (k == s.idx && allow) begin
            n.good = s.good;
          end else begin
            n.seq_err = 1'b1; err = 1'b1; n.good = 0;
            if (s.locked) begin n.alarm = 1'b1; n.locked = 1'b0; end
          end
        end
      end
    end
    if (clr) begin
      n.err = 0; n.alarm = 1'b0;
    end else if (err && n.err < 255) begin
      n.err = n.err + 1;
    end
    return n;
  endfunction

  always @(posedge clk) begin
    m0 <= mstep(m0, reset, sample_en, clr_err, q_in, 1'b0);
    m1 <= mstep(m1, reset, sample_en, clr_err, q_in, 1'b1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      chk("idx0", 32'(idx0), 32'(m0.idx));   chk("idx1", 32'(idx1), 32'(m1.idx));
      chk("iv0", 32'(iv0), 32'(m0.idx_valid)); chk("iv1", 32'(iv1), 32'(m1.idx_valid));
      chk("il0", 32'(il0), 32'(m0.illegal)); chk("il1", 32'(il1), 32'(m1.illegal));
      chk("se0", 32'(se0), 32'(m0.seq_err)); chk("se1", 32'(se1), 32'(m1.seq_err));
      chk("wr0", 32'(wr0), 32'(m0.wrap));    chk("wr1", 32'(wr1), 32'(m1.wrap));
      chk("lk0", 32'(lk0), 32'(m0.locked));  chk("lk1", 32'(lk1), 32'(m1.locked));
      chk("al0", 32'(al0), 32'(m0.alarm));   chk("al1", 32'(al1), 32'(m1.alarm));
      chk("ec0", 32'(ec0), 32'(m0.err));     chk("ec1", 32'(ec1), 32'(m1.err));
    end
  end

  task automatic cyc(input logic [3:0] q, input bit en, input bit clr, input bit rst);
    q_in = q; sample_en = en; clr_err = clr; reset = rst;
    @(negedge clk);
  endtask

  task automatic step_norm();
    cyc(codes[cnt], 1'b1, 1'b0, 1'b0);
    cnt = (cnt + 1) % 8;
  endtask

  initial begin
    int r;
    @(negedge clk);
    cyc(4'b0000, 1'b0, 1'b0, 1'b1);
    chk_on = 1'b1;
    cyc(4'b0000, 1'b0, 1'b0, 1'b1);
    chk("reset_idx", 32'(idx0), 32'd0); chk("reset_lock", 32'(lk0), 32'd0);
    chk("reset_ec", 32'(ec0), 32'd0);   chk("reset_iv", 32'(iv0), 32'd0);

    // Lock acquisition: neutral first sample plus three good steps.
    cnt = 0;
    repeat (3) step_norm();
    chk("s1_not_yet", 32'(lk0), 32'd0);
    step_norm();
    chk("s1_locked", 32'(lk0), 32'd1); chk("s1_idx", 32'(idx0), 32'd3);
    repeat (16) step_norm();
    chk("s1_ec", 32'(ec0), 32'd0);

    // Illegal code while locked.
    cyc(4'b0101, 1'b1, 1'b0, 1'b0);
    chk("s2_illegal", 32'(il0), 32'd1); chk("s2_iv", 32'(iv0), 32'd0);
    chk("s2_lock", 32'(lk0), 32'd0);    chk("s2_alarm", 32'(al0), 32'd1);
    chk("s2_ec", 32'(ec0), 32'd1);
    repeat (4) step_norm();
    chk("s2_relock", 32'(lk0), 32'd1);

    // Skip 0011 -> 1111.
    while (cnt != 3) step_norm();
    cyc(codes[4], 1'b1, 1'b0, 1'b0);
    cnt = 5;
    chk("s3_seq", 32'(se0), 32'd1); chk("s3_idx", 32'(idx0), 32'd4);
    chk("s3_ec", 32'(ec0), 32'd2);  chk("s3_lock", 32'(lk0), 32'd0);

    // Counter restart from idx 5, then clear.
    repeat (4) step_norm();
    while (cnt != 6) step_norm();
    cyc(codes[0], 1'b1, 1'b0, 1'b0);
    cnt = 1;
    chk("s4_seq", 32'(se0), 32'd1); chk("s4_nowrap", 32'(wr0), 32'd0);
    chk("s4_ec", 32'(ec0), 32'd3);
    cyc(codes[1], 1'b1, 1'b1, 1'b0);
    cnt = 2;
    chk("s4_clr_ec", 32'(ec0), 32'd0); chk("s4_clr_al", 32'(al0), 32'd0);
    step_norm();
    chk("s4_not_yet", 32'(lk0), 32'd0);
    step_norm();
    chk("s4_relock", 32'(lk0), 32'd1);

    // Frozen with sample_en low.
    repeat (5) cyc(4'($urandom_range(0, 15)), 1'b0, 1'b0, 1'b0);
    chk("s5_frz_idx", 32'(idx0), 32'd3); chk("s5_frz_lk", 32'(lk0), 32'd1);
    step_norm();
    cyc(codes[(cnt + 7) % 8], 1'b1, 1'b0, 1'b0);
    chk("s5_hold1_se", 32'(se1), 32'd0); chk("s5_hold1_lk", 32'(lk1), 32'd1);
    chk("s5_hold0_se", 32'(se0), 32'd1); chk("s5_hold0_lk", 32'(lk0), 32'd0);
    repeat (6) step_norm();

    // Randomized mix of faults, holds, skips, gaps, clears and resets.
    for (int i = 0; i < 1500; i++) begin
      r = $urandom_range(0, 99);
      if (r < 70) step_norm();
      else if (r < 78) cyc(4'($urandom_range(0, 15)), 1'b1, 1'b0, 1'b0);
      else if (r < 84) cyc(codes[(cnt + 7) % 8], 1'b1, 1'b0, 1'b0);
      else if (r < 88) begin
        cnt = (cnt + $urandom_range(1, 6)) % 8;
        step_norm();
      end
      else if (r < 93) cyc(4'($urandom_range(0, 15)), 1'b0, 1'b0, 1'b0);
      else if (r < 96) cyc(codes[cnt], 1'($urandom_range(0, 1)), 1'b1, 1'b0);
      else if (r < 98) begin
        cyc(codes[cnt], 1'b1, 1'b0, 1'b1);
        cnt = 0;
      end
      else cyc(4'b1010, 1'b1, 1'b0, 1'b0);
    end

    // Saturation, then reset mid-run.
    repeat (300) cyc(4'b0101, 1'b1, 1'b0, 1'b0);
    chk("s6_sat", 32'(ec0), 32'd255);
    cyc(4'b0101, 1'b1, 1'b0, 1'b1);
    chk("s6_rst_ec", 32'(ec0), 32'd0); chk("s6_rst_il", 32'(il0), 32'd0);
    chk("s6_rst_idx", 32'(idx0), 32'd0); chk("s6_rst_al", 32'(al0), 32'd0);
    cnt = 0;
    repeat (4) step_norm();
    chk("s6_relock", 32'(lk0), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
